// File: rtl/regfile_write_scheduler_if.sv
// Write-scheduler bus: two writeback requesters, clear control, and the
// register file write port. The master is the requester/clear side; the slave is the scheduler.
interface regfile_write_scheduler_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Write_Reg;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, clr_start,
        input  ack0, ack1, clr_busy, clr_done, W_Addr, W_Data, Write_Reg
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, clr_start,
        output ack0, ack1, clr_busy, clr_done, W_Addr, W_Data, Write_Reg
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: round-robin arbitration between two
// writeback ports plus a sequencer that zeroes every register, one per cycle.
module regfile_write_scheduler #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    regfile_write_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [AW:0] LAST_CNT = {1'b0, {AW{1'b1}}};

    logic [1:0]    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          write_reg_q, write_reg_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          clr_busy_q, clr_busy_d;
    logic          clr_done_q, clr_done_d;

    logic          elig0, elig1, grant1;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // A port acked this cycle is still holding its old request; mask it once.
    assign elig0    = bus.req0 & ~ack0_q;
    assign elig1    = bus.req1 & ~ack1_q;
    assign grant1   = elig1 & (~elig0 | ~last_grant_q);
    assign win_addr = grant1 ? bus.addr1 : bus.addr0;
    assign win_data = grant1 ? bus.data1 : bus.data0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        write_reg_d  = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        clr_busy_d   = 1'b0;
        clr_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (elig0 | elig1) begin
                    ack0_d       = ~grant1;
                    ack1_d       = grant1;
                    last_grant_d = grant1;
                    // A protected write to r0 is acknowledged but dropped.
                    if (!(PROTECT_R0 && (win_addr == '0))) begin
                        write_reg_d = 1'b1;
                        w_addr_d    = win_addr;
                        w_data_d    = win_data;
                    end
                end
            end
            CLEAR: begin
                write_reg_d = 1'b1;
                w_addr_d    = cnt_q[AW-1:0];
                w_data_d    = '0;
                clr_busy_d  = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            write_reg_q  <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            write_reg_q  <= write_reg_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
        end
    end

    assign bus.Write_Reg = write_reg_q;
    assign bus.W_Addr    = w_addr_q;
    assign bus.W_Data    = w_data_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.clr_done  = clr_done_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: reset, single issue, round-robin,
// clear sequence, r0 protection (both settings) and reset abort during clear.
module tb_regfile_write_scheduler;
    logic Clk;
    logic Reset;

    int n_checks;
    int n_pass;

    regfile_write_scheduler_if #(.AW(5), .DW(32)) bus ();
    regfile_write_scheduler_if #(.AW(5), .DW(32)) bus_np ();

    regfile_write_scheduler #(.AW(5), .DW(32), .PROTECT_R0(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    regfile_write_scheduler #(.AW(5), .DW(32), .PROTECT_R0(1'b0)) dut_np (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_np)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"},   bus.Write_Reg, 0);
        check({tag, "_addr"}, bus.W_Addr,    0);
        check({tag, "_data"}, bus.W_Data,    0);
        check({tag, "_ack0"}, bus.ack0,      0);
        check({tag, "_ack1"}, bus.ack1,      0);
        check({tag, "_busy"}, bus.clr_busy,  0);
        check({tag, "_done"}, bus.clr_done,  0);
    endtask

    initial begin
        logic saw_done;
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b0;
        {bus.req0, bus.req1, bus.clr_start} = '0;
        bus.addr0 = '0; bus.data0 = '0; bus.addr1 = '0; bus.data1 = '0;
        {bus_np.req0, bus_np.req1, bus_np.clr_start} = '0;
        bus_np.addr0 = '0; bus_np.data0 = '0; bus_np.addr1 = '0; bus_np.data1 = '0;

        // Power-on reset
        #3 Reset = 1'b1;
        tick(); tick();
        check_all_zero("rst");
        Reset = 1'b0;
        tick();
        check("idle_wr", bus.Write_Reg, 0);

        // Single port-0 write
        bus.req0 = 1'b1; bus.addr0 = 5'd5; bus.data0 = 32'hDEADBEEF;
        tick();
        check("p0_wr",   bus.Write_Reg, 1);
        check("p0_addr", bus.W_Addr,    5);
        check("p0_data", bus.W_Data,    64'hDEADBEEF);
        check("p0_ack0", bus.ack0,      1);
        check("p0_ack1", bus.ack1,      0);
        bus.req0 = 1'b0;
        tick();
        check("p0_wr_off",  bus.Write_Reg, 0);
        check("p0_ack_off", bus.ack0,      0);
        check("p0_hold",    bus.W_Addr,    5);

        // Reset mid-issue clears outputs asynchronously
        bus.req0 = 1'b1; bus.addr0 = 5'd9; bus.data0 = 32'h1234;
        tick();
        check("mid_wr_pre", bus.Write_Reg, 1);
        #2 Reset = 1'b1;
        #1 check_all_zero("mid_rst");
        bus.req0 = 1'b0;
        Reset = 1'b0;
        tick(); tick();
        check("mid_after_wr", bus.Write_Reg, 0);

        // Both ports held: strict alternation, port 0 first
        bus.req0 = 1'b1; bus.addr0 = 5'd3; bus.data0 = 32'hA0;
        bus.req1 = 1'b1; bus.addr1 = 5'd7; bus.data1 = 32'hB1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_wr",   bus.Write_Reg, 1);
            check("rr_addr", bus.W_Addr, (i % 2 == 0) ? 64'd3 : 64'd7);
            check("rr_data", bus.W_Data, (i % 2 == 0) ? 64'hA0 : 64'hB1);
            check("rr_ack0", bus.ack0,   (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ack1", bus.ack1,   (i % 2 == 0) ? 64'd0 : 64'd1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        check("rr_idle", bus.Write_Reg, 0);

        // Clear beats a pending port-1 request
        bus.clr_start = 1'b1;
        bus.req1 = 1'b1; bus.addr1 = 5'd12; bus.data1 = 32'hCAFE;
        tick();
        bus.clr_start = 1'b0;
        check("clr_enter_ack1", bus.ack1, 0);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("clr_wr",   bus.Write_Reg, 1);
            check("clr_addr", bus.W_Addr,    i);
            check("clr_data", bus.W_Data,    0);
            check("clr_busy", bus.clr_busy,  1);
            check("clr_ack1", bus.ack1,      0);
        end
        tick();
        check("done_pulse", bus.clr_done,  1);
        check("done_busy",  bus.clr_busy,  0);
        check("done_wr",    bus.Write_Reg, 0);
        check("done_ack1",  bus.ack1,      0);
        tick();
        check("post_done",  bus.clr_done,  0);
        check("post_wr",    bus.Write_Reg, 1);
        check("post_addr",  bus.W_Addr,    12);
        check("post_data",  bus.W_Data,    64'hCAFE);
        check("post_ack1",  bus.ack1,      1);
        bus.req1 = 1'b0;
        tick();

        // r0 protection on one instance, none on the other
        bus.req0 = 1'b1;    bus.addr0 = 5'd0;    bus.data0 = 32'h55;
        bus_np.req0 = 1'b1; bus_np.addr0 = 5'd0; bus_np.data0 = 32'h55;
        tick();
        check("r0p_ack0",  bus.ack0,         1);
        check("r0p_wr",    bus.Write_Reg,    0);
        check("r0p_hold",  bus.W_Addr,       12);
        check("r0n_ack0",  bus_np.ack0,      1);
        check("r0n_wr",    bus_np.Write_Reg, 1);
        check("r0n_addr",  bus_np.W_Addr,    0);
        check("r0n_data",  bus_np.W_Data,    64'h55);
        bus.req0 = 1'b0; bus_np.req0 = 1'b0;
        tick();

        // Reset aborts a clear in progress
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("abort_addr_pre", bus.W_Addr,   10);
        check("abort_busy_pre", bus.clr_busy, 1);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", bus.clr_busy,  0);
        check("abort_wr",   bus.Write_Reg, 0);
        check("abort_done", bus.clr_done,  0);
        Reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.clr_done || bus.Write_Reg) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        bus.req0 = 1'b1; bus.addr0 = 5'd4; bus.data0 = 32'h77;
        tick();
        check("abort_idle_ack0", bus.ack0,      1);
        check("abort_idle_wr",   bus.Write_Reg, 1);
        check("abort_idle_addr", bus.W_Addr,    4);
        bus.req0 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
